bch_page_sched: RTL and testbench

- Page scheduler for the BCH decoder buffer RAM. The RAM holds 2**PTR_W frame pages.
- Hands free pages to the input writer and queues per-frame decode results (ptr, decfail, biterr) from the error-locator stage.
- Starts the Chien-search decision stage for one frame at a time and frees the page when the decision stage signals end of frame.
- Sits between the syndrome/locator pipeline and the decision stage. Guarantees a decision run is never restarted mid-frame and a page is never reused before its read-out completes.

---
 rtl/bch_page_sched_if.sv | 33 +++
 rtl/bch_page_sched.sv | 148 ++++++++++++++
 tb/tb_bch_page_sched.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/bch_page_sched_if.sv
// Handshake bundle between the BCH page scheduler, the input writer,
// the error-locator result path and the Chien-search decision stage.
interface bch_page_sched_if #(
  parameter int m     = 4,
  parameter int PTR_W = 1
);
  logic             iwr_sop;
  logic             owr_rdy;
  logic [PTR_W-1:0] owr_ptr;
  logic             ires_val;
  logic [PTR_W-1:0] ires_ptr;
  logic             ires_decfail;
  logic [m-1:0]     ires_biterr;
  logic             odec_val;
  logic [PTR_W-1:0] odec_ptr;
  logic             odec_decfail;
  logic [m-1:0]     odec_biterr;
  logic             idec_eof;
  logic [PTR_W:0]   ofree_cnt;
  logic             oerr;

  modport master (
    output iwr_sop, ires_val, ires_ptr, ires_decfail, ires_biterr, idec_eof,
    input  owr_rdy, owr_ptr, odec_val, odec_ptr, odec_decfail, odec_biterr,
           ofree_cnt, oerr
  );

  modport slave (
    input  iwr_sop, ires_val, ires_ptr, ires_decfail, ires_biterr, idec_eof,
    output owr_rdy, owr_ptr, odec_val, odec_ptr, odec_decfail, odec_biterr,
           ofree_cnt, oerr
  );
endinterface

// File: rtl/bch_page_sched.sv
// Page scheduler for the BCH decoder buffer RAM: allocates free pages, queues
// decode results and runs the decision stage one frame at a time.
module bch_page_sched #(
  parameter int m     = 4,
  parameter int n     = 15,
  parameter int PTR_W = 1
) (
  input  logic            iclk,
  input  logic            ireset,
  input  logic            iclkena,
  bch_page_sched_if.slave bus
);
  localparam int P        = 2**PTR_W;
  localparam int WD_LIMIT = 2*n + 8;
  localparam int WD_W     = $clog2(WD_LIMIT + 1);
  localparam logic [PTR_W:0]  P_CNT   = P[PTR_W:0];
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [P-1:0]     free_mask, mask_next;
  logic [PTR_W:0]   free_cnt, cnt_next;
  logic [PTR_W-1:0] alloc_ptr;

  logic [PTR_W-1:0] fifo_ptr     [P];
  logic             fifo_decfail [P];
  logic [m-1:0]     fifo_biterr  [P];
  logic [PTR_W-1:0] wr_idx, rd_idx;
  logic [PTR_W:0]   count;
  logic             fifo_full, fifo_empty;

  logic [PTR_W-1:0] run_ptr;
  logic [WD_W-1:0]  wd_cnt;
  logic             dec_val, dec_decfail, err;
  logic [PTR_W-1:0] dec_ptr;
  logic [m-1:0]     dec_biterr;

  logic alloc, alloc_err, push, push_err, pop, rel, timeout, eof_err;

  // Lowest-indexed free page wins.
  always_comb begin
    alloc_ptr = '0;
    for (int i = P - 1; i >= 0; i--)
      if (free_mask[i]) alloc_ptr = PTR_W'(i);
  end

  assign fifo_full  = (count == P_CNT);
  assign fifo_empty = (count == '0);

  assign alloc     = bus.iwr_sop & (|free_mask);
  assign alloc_err = bus.iwr_sop & ~(|free_mask);
  // A result for a page nobody owns cannot be genuine, so it is dropped.
  assign push      = bus.ires_val & ~fifo_full & ~free_mask[bus.ires_ptr];
  assign push_err  = bus.ires_val & (fifo_full | free_mask[bus.ires_ptr]);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    rel        = 1'b0;
    timeout    = 1'b0;
    eof_err    = 1'b0;
    case (state)
      IDLE: begin
        eof_err = bus.idec_eof;
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.idec_eof) begin
          rel        = 1'b1;
          state_next = IDLE;
        end else if (wd_cnt == WD_LAST) begin
          rel        = 1'b1;
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The freed page only shows up in alloc_ptr after this edge.
  always_comb begin
    mask_next = free_mask;
    if (alloc) mask_next[alloc_ptr] = 1'b0;
    if (rel)   mask_next[run_ptr]   = 1'b1;
    cnt_next = '0;
    for (int i = 0; i < P; i++)
      cnt_next = cnt_next + {{PTR_W{1'b0}}, mask_next[i]};
  end

  always_ff @(posedge iclk) begin
    if (!ireset) begin
      state       <= IDLE;
      free_mask   <= '1;
      free_cnt    <= P_CNT;
      wr_idx      <= '0;
      rd_idx      <= '0;
      count       <= '0;
      run_ptr     <= '0;
      wd_cnt      <= '0;
      dec_val     <= 1'b0;
      dec_ptr     <= '0;
      dec_decfail <= 1'b0;
      dec_biterr  <= '0;
      err         <= 1'b0;
    end else if (iclkena) begin
      state     <= state_next;
      free_mask <= mask_next;
      free_cnt  <= cnt_next;
      dec_val   <= pop;
      if (push) begin
        fifo_ptr[wr_idx]     <= bus.ires_ptr;
        fifo_decfail[wr_idx] <= bus.ires_decfail;
        fifo_biterr[wr_idx]  <= bus.ires_biterr;
        wr_idx               <= wr_idx + 1'b1;
      end
      if (pop) begin
        rd_idx      <= rd_idx + 1'b1;
        run_ptr     <= fifo_ptr[rd_idx];
        dec_ptr     <= fifo_ptr[rd_idx];
        dec_decfail <= fifo_decfail[rd_idx];
        dec_biterr  <= fifo_biterr[rd_idx];
        wd_cnt      <= '0;
      end else if (state == RUN) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (alloc_err | push_err | eof_err | timeout) err <= 1'b1;
    end
  end

  assign bus.owr_rdy      = |free_mask;
  assign bus.owr_ptr      = alloc_ptr;
  assign bus.odec_val     = dec_val & iclkena;
  assign bus.odec_ptr     = dec_ptr;
  assign bus.odec_decfail = dec_decfail;
  assign bus.odec_biterr  = dec_biterr;
  assign bus.ofree_cnt    = free_cnt;
  assign bus.oerr         = err;
endmodule

// File: tb/tb_bch_page_sched.sv
// Scoreboard bench for bch_page_sched: expected dispatches are queued by the
// stimulus thread and compared by a negedge monitor.
module tb_bch_page_sched;
  localparam int M     = 4;
  localparam int N     = 15;
  localparam int PTR_W = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic clkena;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   disp_cnt = 0;
  logic [PTR_W+M:0] exp_q[$];

  bch_page_sched_if #(.m(M), .PTR_W(PTR_W)) bus ();

  bch_page_sched #(.m(M), .n(N), .PTR_W(PTR_W)) dut (
    .iclk    (clk),
    .ireset  (rst_n),
    .iclkena (clkena),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every decision-stage start must match the oldest queued result.
  always @(negedge clk) begin
    if (bus.odec_val === 1'b1) begin
      disp_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_dispatch: got ptr=%0d decfail=%0d biterr=%0d, expected none",
                 bus.odec_ptr, bus.odec_decfail, bus.odec_biterr);
      end else begin
        logic [PTR_W+M:0] e;
        e = exp_q.pop_front();
        if ({bus.odec_ptr, bus.odec_decfail, bus.odec_biterr} !== e) begin
          failures++;
          $display("[TB] FAIL dispatch: got ptr=%0d decfail=%0d biterr=%0d, expected ptr=%0d decfail=%0d biterr=%0d",
                   bus.odec_ptr, bus.odec_decfail, bus.odec_biterr,
                   e[PTR_W+M:M+1], e[M], e[M-1:0]);
        end
      end
    end
  end

  task automatic applyStimulus(input int ptr, input int decfail, input int biterr,
                               input bit expect_dispatch);
    bus.ires_val     = 1'b1;
    bus.ires_ptr     = PTR_W'(ptr);
    bus.ires_decfail = decfail[0];
    bus.ires_biterr  = M'(biterr);
    if (expect_dispatch) exp_q.push_back({PTR_W'(ptr), decfail[0], M'(biterr)});
    tick();
    bus.ires_val = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic allocAll();
    bus.iwr_sop = 1'b1;
    tick();
    tick();
    bus.iwr_sop = 1'b0;
  endtask

  task automatic pulseEof(output int at_cyc);
    bus.idec_eof = 1'b1;
    at_cyc = cyc;
    tick();
    bus.idec_eof = 1'b0;
  endtask

  task automatic waitDispatch(output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.odec_val === 1'b1) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL dispatch_timeout: got no odec_val, expected one within 12 cycles");
    end
  endtask

  initial begin
    int t_disp, t_eof, base;
    rst_n            = 1'b0;
    clkena           = 1'b1;
    bus.iwr_sop      = 1'b0;
    bus.ires_val     = 1'b0;
    bus.ires_ptr     = '0;
    bus.ires_decfail = 1'b0;
    bus.ires_biterr  = '0;
    bus.idec_eof     = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    checkOutput("reset_owr_rdy", bus.owr_rdy, 1);
    checkOutput("reset_owr_ptr", bus.owr_ptr, 0);
    checkOutput("reset_free_cnt", bus.ofree_cnt, 2);
    checkOutput("reset_odec_val", bus.odec_val, 0);
    checkOutput("reset_oerr", bus.oerr, 0);

    // Clock enable low must swallow an allocation request.
    clkena = 1'b0;
    bus.iwr_sop = 1'b1;
    tick();
    bus.iwr_sop = 1'b0;
    clkena = 1'b1;
    checkOutput("clkena_free_cnt", bus.ofree_cnt, 2);
    checkOutput("clkena_owr_ptr", bus.owr_ptr, 0);

    bus.iwr_sop = 1'b1;
    tick();
    checkOutput("alloc1_owr_ptr", bus.owr_ptr, 1);
    checkOutput("alloc1_free_cnt", bus.ofree_cnt, 1);
    tick();
    bus.iwr_sop = 1'b0;
    checkOutput("alloc2_owr_rdy", bus.owr_rdy, 0);
    checkOutput("alloc2_free_cnt", bus.ofree_cnt, 0);
    checkOutput("alloc2_oerr", bus.oerr, 0);
    bus.iwr_sop = 1'b1;
    tick();
    bus.iwr_sop = 1'b0;
    checkOutput("overalloc_oerr", bus.oerr, 1);
    checkOutput("overalloc_free_cnt", bus.ofree_cnt, 0);

    // Single frame, eof after a 17-cycle run.
    doReset();
    allocAll();
    applyStimulus(1, 1, 3, 1'b1);
    waitDispatch(t_disp);
    repeat (16) tick();
    checkOutput("run_free_cnt", bus.ofree_cnt, 0);
    pulseEof(t_eof);
    checkOutput("eof_free_cnt", bus.ofree_cnt, 1);
    checkOutput("eof_owr_ptr", bus.owr_ptr, 1);
    checkOutput("eof_oerr", bus.oerr, 0);

    // Back-to-back results: only one run at a time, 2-cycle restart gap.
    doReset();
    allocAll();
    base = disp_cnt;
    applyStimulus(0, 0, 5, 1'b1);
    applyStimulus(1, 1, 10, 1'b1);
    checkOutput("b2b_first_val", bus.odec_val, 1);
    repeat (3) tick();
    checkOutput("b2b_single_dispatch", disp_cnt - base, 1);
    pulseEof(t_eof);
    waitDispatch(t_disp);
    checkOutput("b2b_restart_gap", t_disp - t_eof, 2);
    repeat (4) tick();
    pulseEof(t_eof);
    checkOutput("b2b_free_cnt", bus.ofree_cnt, 2);
    checkOutput("b2b_oerr", bus.oerr, 0);

    // Watchdog: 38 RUN cycles without eof frees the page and flags oerr.
    doReset();
    allocAll();
    applyStimulus(0, 0, 1, 1'b1);
    waitDispatch(t_disp);
    applyStimulus(1, 0, 2, 1'b1);
    repeat (35) tick();
    checkOutput("wd_early_free_cnt", bus.ofree_cnt, 0);
    tick();
    checkOutput("wd_last_oerr", bus.oerr, 0);
    tick();
    checkOutput("wd_free_cnt", bus.ofree_cnt, 1);
    checkOutput("wd_oerr", bus.oerr, 1);
    checkOutput("wd_owr_ptr", bus.owr_ptr, 0);
    waitDispatch(t_disp);
    tick();
    pulseEof(t_eof);
    checkOutput("wd_done_free_cnt", bus.ofree_cnt, 2);

    // Reset mid-run with one entry still queued.
    doReset();
    allocAll();
    applyStimulus(0, 0, 7, 1'b1);
    applyStimulus(1, 1, 4, 1'b0);
    doReset();
    checkOutput("midrst_free_cnt", bus.ofree_cnt, 2);
    checkOutput("midrst_owr_rdy", bus.owr_rdy, 1);
    checkOutput("midrst_oerr", bus.oerr, 0);
    base = disp_cnt;
    repeat (5) tick();
    checkOutput("midrst_no_dispatch", disp_cnt - base, 0);
    pulseEof(t_eof);
    checkOutput("late_eof_oerr", bus.oerr, 1);

    // Result for a free page is dropped.
    doReset();
    base = disp_cnt;
    applyStimulus(1, 0, 9, 1'b0);
    repeat (4) tick();
    checkOutput("drop_oerr", bus.oerr, 1);
    checkOutput("drop_no_dispatch", disp_cnt - base, 0);

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
